// File: rtl/tomasulo_rs_if.sv
// Shared types and the dispatch / CDB / issue bus of the tomasulo_rs
// reservation station. The master side dispatches ops and drives the CDB;
// the slave side (the reservation station) accepts ops and issues them.

package tomasulo_rs_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_MOVI = 4'd7
    } opcode_t;

    typedef logic [15:0] imm_t;
    typedef logic [3:0]  robid_t;
    typedef logic [4:0]  tag_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic   vld;
        tag_t   tag;
        word_t  wdata;
        robid_t robid;
    } cdb_t;

    typedef struct packed {
        opcode_t     op;
        word_t [1:0] rdata;
        imm_t        imm;
        tag_t        tag;
        robid_t      robid;
    } issue_t;
endpackage

interface tomasulo_rs_if;
    import tomasulo_rs_pkg::*;

    logic        disp_vld;
    logic        disp_rdy;
    opcode_t     disp_op;
    imm_t        disp_imm;
    robid_t      disp_robid;
    logic [1:0]  disp_src_rdy;
    tag_t [1:0]  disp_src_tag;
    word_t [1:0] disp_src_data;
    tag_t        disp_tag;
    cdb_t        cdb;
    logic        iss_vld;
    issue_t      iss;

    modport master (
        output disp_vld, disp_op, disp_imm, disp_robid,
               disp_src_rdy, disp_src_tag, disp_src_data, cdb,
        input  disp_rdy, disp_tag, iss_vld, iss
    );

    modport slave (
        input  disp_vld, disp_op, disp_imm, disp_robid,
               disp_src_rdy, disp_src_tag, disp_src_data, cdb,
        output disp_rdy, disp_tag, iss_vld, iss
    );
endinterface

// File: rtl/tomasulo_rs.sv
// Reservation station in front of the execution logic: holds dispatched ops,
// wakes pending operands from the CDB and issues the oldest ready op per cycle.
// Define TOMASULO_RS_BYPASS_EN to let an op issue in the same cycle the CDB
// broadcasts its last missing operand.

module tomasulo_rs
    import tomasulo_rs_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned TAG_BASE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    tomasulo_rs_if.slave           bus,
    output logic [$clog2(N+1)-1:0] occupancy
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned OW = $clog2(N+1);

    logic [N-1:0] vld;
    opcode_t      e_op     [N];
    imm_t         e_imm    [N];
    robid_t       e_robid  [N];
    logic [1:0]   src_rdy  [N];
    tag_t [1:0]   src_tag  [N];
    word_t [1:0]  src_data [N];
    // age[i][j] set means entry i is younger than entry j
    logic [N-1:0] age      [N];

    logic [1:0]   cdb_hit  [N];
    logic [1:0]   opr_ok   [N];
    logic [N-1:0] rdy;
    logic [1:0]   disp_cap;

    logic         sel_hit;
    logic [IW-1:0] sel_idx;
    tag_t         sel_tag;
    logic         older_rdy;

    logic         free_hit;
    logic [IW-1:0] free_idx;
    tag_t         free_tag;

    logic         accept;
    logic         iss_fire;
    issue_t       iss_c;

    // CDB tag matches against pending operands and the operands being dispatched
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned k = 0; k < 2; k++) begin
                cdb_hit[i][k] = bus.cdb.vld && (bus.cdb.tag != '0) && !src_rdy[i][k]
                                && (src_tag[i][k] == bus.cdb.tag);
            end
        end
        for (int unsigned k = 0; k < 2; k++) begin
            disp_cap[k] = bus.cdb.vld && (bus.cdb.tag != '0)
                          && (bus.disp_src_tag[k] == bus.cdb.tag);
        end
    end

    // Entry readiness; MOVI does not wait on its operands
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
`ifdef TOMASULO_RS_BYPASS_EN
            opr_ok[i] = src_rdy[i] | cdb_hit[i];
`else
            opr_ok[i] = src_rdy[i];
`endif
            rdy[i] = vld[i] && ((e_op[i] == OP_MOVI) || (&opr_ok[i]));
        end
    end

    // Oldest-ready select: a ready entry with no ready entry older than it
    always_comb begin
        sel_hit   = 1'b0;
        sel_idx   = '0;
        sel_tag   = '0;
        older_rdy = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            older_rdy = 1'b0;
            for (int unsigned j = 0; j < N; j++) begin
                if (rdy[j] && age[i][j]) older_rdy = 1'b1;
            end
            if (rdy[i] && !older_rdy && !sel_hit) begin
                sel_hit = 1'b1;
                sel_idx = i[IW-1:0];
                sel_tag = tag_t'(TAG_BASE + i);
            end
        end
    end

    // Lowest-index free entry, from current state only
    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        free_tag = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!vld[i] && !free_hit) begin
                free_hit = 1'b1;
                free_idx = i[IW-1:0];
                free_tag = tag_t'(TAG_BASE + i);
            end
        end
    end

    assign accept       = bus.disp_vld && free_hit && !flush;
    assign iss_fire     = sel_hit && !flush;
    assign bus.disp_rdy = free_hit;
    assign bus.disp_tag = free_tag;
    assign bus.iss_vld  = iss_fire;
    assign bus.iss      = iss_c;

    // Issue payload from the selected entry, zero when nothing issues
    always_comb begin
        iss_c = '0;
        if (iss_fire) begin
            iss_c.op    = e_op[sel_idx];
            iss_c.imm   = e_imm[sel_idx];
            iss_c.robid = e_robid[sel_idx];
            iss_c.tag   = sel_tag;
            for (int unsigned k = 0; k < 2; k++) begin
                iss_c.rdata[k] = src_data[sel_idx][k];
`ifdef TOMASULO_RS_BYPASS_EN
                if (cdb_hit[sel_idx][k]) iss_c.rdata[k] = bus.cdb.wdata;
`endif
            end
        end
    end

    // Valid-entry count
    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < N; i++) begin
            occupancy = occupancy + {{(OW-1){1'b0}}, vld[i]};
        end
    end

    // Entry state: wakeup, dispatch write, issue invalidate; rst/flush drop everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld <= '0;
            for (int unsigned i = 0; i < N; i++) age[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned k = 0; k < 2; k++) begin
                    if (vld[i] && cdb_hit[i][k]) begin
                        src_rdy[i][k]  <= 1'b1;
                        src_data[i][k] <= bus.cdb.wdata;
                    end
                end
            end
            if (accept) begin
                vld[free_idx]     <= 1'b1;
                e_op[free_idx]    <= bus.disp_op;
                e_imm[free_idx]   <= bus.disp_imm;
                e_robid[free_idx] <= bus.disp_robid;
                for (int unsigned k = 0; k < 2; k++) begin
                    src_tag[free_idx][k] <= bus.disp_src_tag[k];
                    if (bus.disp_src_rdy[k]) begin
                        src_rdy[free_idx][k]  <= 1'b1;
                        src_data[free_idx][k] <= bus.disp_src_data[k];
                    end else if (disp_cap[k]) begin
                        src_rdy[free_idx][k]  <= 1'b1;
                        src_data[free_idx][k] <= bus.cdb.wdata;
                    end else begin
                        src_rdy[free_idx][k]  <= 1'b0;
                        src_data[free_idx][k] <= '0;
                    end
                end
                age[free_idx] <= vld;
                for (int unsigned j = 0; j < N; j++) age[j][free_idx] <= 1'b0;
            end
            // Placed after the dispatch write so the issued column wins in the new row
            if (iss_fire) begin
                vld[sel_idx] <= 1'b0;
                age[sel_idx] <= '0;
                for (int unsigned j = 0; j < N; j++) age[j][sel_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tomasulo_rs.sv
// Directed self-checking bench for tomasulo_rs (N=4, TAG_BASE=1).
// Latency expectations follow TOMASULO_RS_BYPASS_EN when it is defined.
`timescale 1ns/1ps

module tb_tomasulo_rs;
    import tomasulo_rs_pkg::*;

    localparam int unsigned N        = 4;
    localparam int unsigned TAG_BASE = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] occupancy;
    int         checks = 0;
    int         errors = 0;

    tomasulo_rs_if rs_if();

    tomasulo_rs #(.N(N), .TAG_BASE(TAG_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (rs_if.slave),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_if.disp_vld      = 1'b0;
        rs_if.disp_op       = OP_ADD;
        rs_if.disp_imm      = '0;
        rs_if.disp_robid    = '0;
        rs_if.disp_src_rdy  = '0;
        rs_if.disp_src_tag  = '0;
        rs_if.disp_src_data = '0;
        rs_if.cdb           = '0;
        flush               = 1'b0;
    endtask

    task automatic disp(input opcode_t op, input logic [1:0] srdy, input tag_t t0, input tag_t t1,
                        input word_t d0, input word_t d1, input robid_t rob, input imm_t imm);
        rs_if.disp_vld         = 1'b1;
        rs_if.disp_op          = op;
        rs_if.disp_imm         = imm;
        rs_if.disp_robid       = rob;
        rs_if.disp_src_rdy     = srdy;
        rs_if.disp_src_tag[0]  = t0;
        rs_if.disp_src_tag[1]  = t1;
        rs_if.disp_src_data[0] = d0;
        rs_if.disp_src_data[1] = d1;
    endtask

    task automatic bcast(input tag_t t, input word_t d);
        rs_if.cdb.vld   = 1'b1;
        rs_if.cdb.tag   = t;
        rs_if.cdb.wdata = d;
        rs_if.cdb.robid = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // 1: reset state, then a ready op issues the cycle after acceptance
        check("rst_disp_rdy", rs_if.disp_rdy, 1);
        check("rst_iss_vld", rs_if.iss_vld, 0);
        check("rst_occ", occupancy, 0);
        check("rst_iss_zero", rs_if.iss, 0);
        disp(OP_AND, 2'b11, 0, 0, 32'hF0, 32'h3C, 2, 0);
        check("t1_disp_tag", rs_if.disp_tag, 1);
        step(); idle();
        check("t1_iss_vld", rs_if.iss_vld, 1);
        check("t1_op", rs_if.iss.op, OP_AND);
        check("t1_rdata0", rs_if.iss.rdata[0], 32'hF0);
        check("t1_rdata1", rs_if.iss.rdata[1], 32'h3C);
        check("t1_tag", rs_if.iss.tag, TAG_BASE);
        check("t1_robid", rs_if.iss.robid, 2);
        check("t1_occ1", occupancy, 1);
        step();
        check("t1_occ0", occupancy, 0);
        check("t1_idle", rs_if.iss_vld, 0);

        // 2: operand woken by CDB two cycles after dispatch
        disp(OP_OR, 2'b10, 3, 0, 0, 32'h01, 5, 0);
        check("t2_disp_tag", rs_if.disp_tag, 1);
        step(); idle();
        check("t2_wait", rs_if.iss_vld, 0);
        step();
        bcast(3, 32'h80);
`ifdef TOMASULO_RS_BYPASS_EN
        check("t2_iss_vld", rs_if.iss_vld, 1);
        check("t2_rdata0", rs_if.iss.rdata[0], 32'h80);
        check("t2_rdata1", rs_if.iss.rdata[1], 32'h01);
        check("t2_robid", rs_if.iss.robid, 5);
        step(); idle();
        check("t2_after", rs_if.iss_vld, 0);
`else
        check("t2_bubble", rs_if.iss_vld, 0);
        step(); idle();
        check("t2_iss_vld", rs_if.iss_vld, 1);
        check("t2_rdata0", rs_if.iss.rdata[0], 32'h80);
        check("t2_rdata1", rs_if.iss.rdata[1], 32'h01);
        check("t2_robid", rs_if.iss.robid, 5);
        step();
`endif
        check("t2_occ", occupancy, 0);

        // 3: fill, wake entry 2, held dispatch lands in entry 2
        for (int i = 0; i < 4; i++) begin
            disp(OP_SUB, 2'b10, tag_t'(20 + i), 0, 0, word_t'(i), robid_t'(i), 0);
            check("t3_fill_rdy", rs_if.disp_rdy, 1);
            check("t3_fill_tag", rs_if.disp_tag, TAG_BASE + i);
            step();
        end
        check("t3_full", rs_if.disp_rdy, 0);
        check("t3_occ4", occupancy, 4);
        disp(OP_ADD, 2'b11, 0, 0, 32'h7, 32'h8, 9, 0);
        bcast(22, 32'h33);
        check("t3_full_bcast", rs_if.disp_rdy, 0);
`ifdef TOMASULO_RS_BYPASS_EN
        check("t3_e2_vld", rs_if.iss_vld, 1);
        check("t3_e2_tag", rs_if.iss.tag, 3);
        check("t3_e2_rdata0", rs_if.iss.rdata[0], 32'h33);
        step();
        rs_if.cdb = '0;
`else
        check("t3_e2_bubble", rs_if.iss_vld, 0);
        step();
        rs_if.cdb = '0;
        check("t3_e2_vld", rs_if.iss_vld, 1);
        check("t3_e2_tag", rs_if.iss.tag, 3);
        check("t3_e2_rdata0", rs_if.iss.rdata[0], 32'h33);
        check("t3_still_full", rs_if.disp_rdy, 0);
        step();
`endif
        check("t3_free", rs_if.disp_rdy, 1);
        check("t3_new_tag", rs_if.disp_tag, 3);
        step(); idle();
        check("t3_new_vld", rs_if.iss_vld, 1);
        check("t3_new_tag_iss", rs_if.iss.tag, 3);
        check("t3_new_robid", rs_if.iss.robid, 9);
        check("t3_new_rdata0", rs_if.iss.rdata[0], 32'h7);
        check("t3_new_rdata1", rs_if.iss.rdata[1], 32'h8);
        check("t3_occ_before", occupancy, 4);
        step();
        check("t3_occ3", occupancy, 3);

        // 6a: flush with three valid entries, a dispatch and a matching broadcast
        disp(OP_ADD, 2'b11, 0, 0, 32'h1, 32'h1, 10, 0);
        bcast(20, 32'h44);
        flush = 1'b1;
        check("t6_flush_iss", rs_if.iss_vld, 0);
        step(); idle();
        check("t6_occ", occupancy, 0);
        check("t6_iss_vld", rs_if.iss_vld, 0);
        check("t6_disp_rdy", rs_if.disp_rdy, 1);
        step();
        check("t6_dropped", rs_if.iss_vld, 0);
        check("t6_occ_after", occupancy, 0);

        // 4: entries 3, 1, 0 (in that age order) woken by one tag
        disp(OP_XOR, 2'b10, 24, 0, 0, 0, 0, 0); step();
        disp(OP_XOR, 2'b10, 25, 0, 0, 0, 0, 0); step();
        disp(OP_XOR, 2'b10, 26, 0, 0, 0, 0, 0); step();
        disp(OP_XOR, 2'b10, 30, 0, 0, 32'h3, 3, 0); step(); idle();
        bcast(25, 32'h0); step(); idle(); step();
        check("t4_e1_free", rs_if.disp_rdy, 1);
        check("t4_e1_tag", rs_if.disp_tag, 2);
        disp(OP_XOR, 2'b10, 30, 0, 0, 32'h1, 1, 0); step(); idle();
        bcast(24, 32'h0); step(); idle(); step();
        check("t4_e0_tag", rs_if.disp_tag, 1);
        disp(OP_XOR, 2'b00, 30, 30, 0, 0, 6, 0); step(); idle();
        check("t4_occ4", occupancy, 4);
        bcast(30, 32'h55);
`ifndef TOMASULO_RS_BYPASS_EN
        check("t4_bubble", rs_if.iss_vld, 0);
        step(); idle();
`endif
        check("t4_first_vld", rs_if.iss_vld, 1);
        check("t4_first_tag", rs_if.iss.tag, 4);
        check("t4_first_robid", rs_if.iss.robid, 3);
        check("t4_first_rdata0", rs_if.iss.rdata[0], 32'h55);
        step(); idle();
        check("t4_second_tag", rs_if.iss.tag, 2);
        check("t4_second_robid", rs_if.iss.robid, 1);
        check("t4_second_rdata0", rs_if.iss.rdata[0], 32'h55);
        step();
        check("t4_third_tag", rs_if.iss.tag, 1);
        check("t4_third_robid", rs_if.iss.robid, 6);
        check("t4_both_rdata0", rs_if.iss.rdata[0], 32'h55);
        check("t4_both_rdata1", rs_if.iss.rdata[1], 32'h55);
        step();
        check("t4_done", rs_if.iss_vld, 0);
        check("t4_occ1", occupancy, 1);
        flush = 1'b1; step(); idle();

        // MOVI issues regardless of operand readiness
        disp(OP_MOVI, 2'b00, 27, 27, 0, 0, 7, 16'h1234);
        step(); idle();
        check("movi_vld", rs_if.iss_vld, 1);
        check("movi_op", rs_if.iss.op, OP_MOVI);
        check("movi_imm", rs_if.iss.imm, 16'h1234);
        check("movi_robid", rs_if.iss.robid, 7);
        step();
        check("movi_occ", occupancy, 0);

        // 5: capture at dispatch from a same-cycle broadcast
        disp(OP_ADD, 2'b10, 5, 0, 0, 32'h2, 8, 0);
        bcast(5, 32'hAA);
        check("t5_disp_tag", rs_if.disp_tag, 1);
        step(); idle();
        check("t5_iss_vld", rs_if.iss_vld, 1);
        check("t5_rdata0", rs_if.iss.rdata[0], 32'hAA);
        check("t5_rdata1", rs_if.iss.rdata[1], 32'h2);
        step();
        check("t5_occ", occupancy, 0);

        // 6b: reset mid-run drops pending entries
        disp(OP_SUB, 2'b10, 28, 0, 0, 0, 1, 0); step();
        disp(OP_SUB, 2'b10, 28, 0, 0, 0, 2, 0); step(); idle();
        check("t6_rst_occ_before", occupancy, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_disp_rdy", rs_if.disp_rdy, 1);
        check("t6_rst_iss_vld", rs_if.iss_vld, 0);
        check("t6_rst_iss", rs_if.iss, 0);
        bcast(28, 32'h9);
        step(); idle();
        check("t6_rst_lost", rs_if.iss_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
